// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage encodings, the ID/EX payload and the forwarding mux.
package mips_pkg;

   localparam int unsigned WIDTH     = 32;
   localparam int unsigned MD_CYCLES = 32;
   localparam int unsigned REG_W     = 5;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_MFHI = 4'b1000;
   localparam logic [3:0] ALU_MFLO = 4'b1001;
   localparam logic [3:0] ALU_NOR  = 4'b1100;

   localparam logic [1:0] MD_NONE  = 2'b00;
   localparam logic [1:0] MD_MULT  = 2'b01;
   localparam logic [1:0] MD_MULTU = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   localparam logic [1:0] FWD_RF   = 2'b00;
   localparam logic [1:0] FWD_RESW = 2'b01;
   localparam logic [1:0] FWD_ALUM = 2'b10;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_BUSY  = 2'b01;
   localparam logic [1:0] ST_DONE  = 2'b10;

   typedef struct packed {
      logic             jump;
      logic             reg_write;
      logic             mem_write;
      logic [1:0]       memto_reg;
      logic [3:0]       alu_ctrl;
      logic             alu_src;
      logic             reg_dst;
      logic [1:0]       mult_op;
      logic [WIDTH-1:0] rd1;
      logic [WIDTH-1:0] rd2;
      logic [WIDTH-1:0] sign_imm;
      logic [WIDTH-1:0] pc_plus4;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] rd;
   } idex_t;

   // Select 11 is unused by the hazard unit and falls back to the register file value.
   function automatic logic [WIDTH-1:0] fwd_sel(input logic [WIDTH-1:0] rf,
                                                input logic [WIDTH-1:0] res_w,
                                                input logic [WIDTH-1:0] alu_m,
                                                input logic [1:0]       sel);
      logic [WIDTH-1:0] r;
      r = rf;
      case (sel)
         FWD_RF:   r = rf;
         FWD_RESW: r = res_w;
         FWD_ALUM: r = alu_m;
         default:  r = rf;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Bus between decode/hazard logic and the EX stage, plus EX outputs toward the memory stage.
interface execute_stage_if;
   import mips_pkg::*;

   logic             FlushE;
   logic             jumpD, RegWriteD, MemWriteD;
   logic [1:0]       MemtoRegD;
   logic [3:0]       ALUControlD;
   logic             ALUSrcD, RegDstD;
   logic [1:0]       MultOpD;
   logic [WIDTH-1:0] RD1D, RD2D, SignImmD, PCPlus4D;
   logic [REG_W-1:0] RsD, RtD, RdD;
   logic [1:0]       ForwardAE, ForwardBE;
   logic [WIDTH-1:0] ResultW, ALUMultOutM;

   logic             jumpE, RegWriteE, MemWriteE;
   logic [1:0]       MemtoRegE;
   logic [REG_W-1:0] WriteRegE, RsE, RtE;
   logic [WIDTH-1:0] ALUMultOutE, WriteDataE, PCPlus4E;
   logic             MultBusyE;

   modport slave (
      input  FlushE, jumpD, RegWriteD, MemWriteD, MemtoRegD, ALUControlD, ALUSrcD, RegDstD,
             MultOpD, RD1D, RD2D, SignImmD, PCPlus4D, RsD, RtD, RdD, ForwardAE, ForwardBE,
             ResultW, ALUMultOutM,
      output jumpE, RegWriteE, MemWriteE, MemtoRegE, WriteRegE, RsE, RtE, ALUMultOutE,
             WriteDataE, PCPlus4E, MultBusyE
   );

   modport master (
      output FlushE, jumpD, RegWriteD, MemWriteD, MemtoRegD, ALUControlD, ALUSrcD, RegDstD,
             MultOpD, RD1D, RD2D, SignImmD, PCPlus4D, RsD, RtD, RdD, ForwardAE, ForwardBE,
             ResultW, ALUMultOutM,
      input  jumpE, RegWriteE, MemWriteE, MemtoRegE, WriteRegE, RsE, RtE, ALUMultOutE,
             WriteDataE, PCPlus4E, MultBusyE
   );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative one-bit-per-cycle shift-add multiplier / restoring divider that owns HI and LO.
module mult_div_unit
   import mips_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_c,
   output logic             done_c,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CNT_W = $clog2(MD_CYCLES);
   localparam int unsigned DW    = 2 * WIDTH;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       op_q, op_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH:0]   mul_sum, div_sh, div_diff;
   logic [DW-1:0]    product, prod_neg;
   logic [WIDTH-1:0] div_hi, div_lo;

   // acc_hi/acc_lo hold {partial product, multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
      product  = {mul_sum, acc_lo_q[WIDTH-1:1]};
      prod_neg = ~product + DW'(1);
      div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, opb_q};
      div_hi   = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      div_lo   = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      op_d     = op_q;
      neg_d    = neg_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opb_d    = opb_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_c   = 1'b0;
      done_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               busy_c   = 1'b1;
               state_d  = ST_BUSY;
               count_d  = '0;
               op_d     = op_i;
               acc_hi_d = '0;
               if (op_i == MD_MULT) begin
                  neg_d    = a_i[WIDTH-1] ^ b_i[WIDTH-1];
                  acc_lo_d = a_i[WIDTH-1] ? (~a_i + WIDTH'(1)) : a_i;
                  opb_d    = b_i[WIDTH-1] ? (~b_i + WIDTH'(1)) : b_i;
               end else begin
                  neg_d    = 1'b0;
                  acc_lo_d = a_i;
                  opb_d    = b_i;
               end
            end
         end
         ST_BUSY: begin
            busy_c  = 1'b1;
            count_d = count_q + CNT_W'(1);
            if (op_q == MD_DIVU) begin
               acc_hi_d = div_hi;
               acc_lo_d = div_lo;
            end else begin
               acc_hi_d = product[DW-1:WIDTH];
               acc_lo_d = product[WIDTH-1:0];
            end
            if (count_q == CNT_W'(MD_CYCLES - 1)) begin
               state_d = ST_DONE;
               if (op_q == MD_DIVU) begin
                  hi_d = div_hi;
                  lo_d = div_lo;
               end else begin
                  {hi_d, lo_d} = neg_q ? prod_neg : product;
               end
            end
         end
         ST_DONE: begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opb_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opb_q    <= opb_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: ID/EX register, operand forwarding, ALU, and HI/LO via the mult/div unit.
module execute_stage
   import mips_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   execute_stage_if.slave ex
);

   idex_t            idex_q, idex_d;
   logic [WIDTH-1:0] src_a, src_b, write_data, alu_c, hi, lo;
   logic             md_busy, md_done, bubble;

   // A running mult/div freezes ID/EX, which also makes FlushE ineffective until it ends.
   always_comb begin
      idex_d = idex_q;
      if (!md_busy) begin
         if (ex.FlushE) begin
            idex_d = '0;
         end else begin
            idex_d.jump      = ex.jumpD;
            idex_d.reg_write = ex.RegWriteD;
            idex_d.mem_write = ex.MemWriteD;
            idex_d.memto_reg = ex.MemtoRegD;
            idex_d.alu_ctrl  = ex.ALUControlD;
            idex_d.alu_src   = ex.ALUSrcD;
            idex_d.reg_dst   = ex.RegDstD;
            idex_d.mult_op   = ex.MultOpD;
            idex_d.rd1       = ex.RD1D;
            idex_d.rd2       = ex.RD2D;
            idex_d.sign_imm  = ex.SignImmD;
            idex_d.pc_plus4  = ex.PCPlus4D;
            idex_d.rs        = ex.RsD;
            idex_d.rt        = ex.RtD;
            idex_d.rd        = ex.RdD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) idex_q <= '0;
      else      idex_q <= idex_d;
   end

   assign src_a      = fwd_sel(idex_q.rd1, ex.ResultW, ex.ALUMultOutM, ex.ForwardAE);
   assign write_data = fwd_sel(idex_q.rd2, ex.ResultW, ex.ALUMultOutM, ex.ForwardBE);
   assign src_b      = idex_q.alu_src ? idex_q.sign_imm : write_data;

   always_comb begin
      alu_c = '0;
      case (idex_q.alu_ctrl)
         ALU_AND:  alu_c = src_a & src_b;
         ALU_OR:   alu_c = src_a | src_b;
         ALU_ADD:  alu_c = src_a + src_b;
         ALU_SUB:  alu_c = src_a - src_b;
         ALU_SLT:  alu_c = WIDTH'($signed(src_a) < $signed(src_b));
         ALU_NOR:  alu_c = ~(src_a | src_b);
         ALU_MFHI: alu_c = hi;
         ALU_MFLO: alu_c = lo;
         default:  alu_c = '0;
      endcase
   end

   mult_div_unit u_md (
      .clk     (clk),
      .rst     (rst),
      .start_i (idex_q.mult_op != MD_NONE),
      .op_i    (idex_q.mult_op),
      .a_i     (src_a),
      .b_i     (src_b),
      .busy_c  (md_busy),
      .done_c  (md_done),
      .hi_o    (hi),
      .lo_o    (lo)
   );

   // The instruction held during a mult/div and its DONE cycle is issued downstream as a bubble.
   assign bubble         = md_busy | md_done;
   assign ex.jumpE       = idex_q.jump      & ~bubble;
   assign ex.RegWriteE   = idex_q.reg_write & ~bubble;
   assign ex.MemWriteE   = idex_q.mem_write & ~bubble;
   assign ex.MemtoRegE   = idex_q.memto_reg;
   assign ex.WriteRegE   = idex_q.reg_dst ? idex_q.rd : idex_q.rt;
   assign ex.RsE         = idex_q.rs;
   assign ex.RtE         = idex_q.rt;
   assign ex.ALUMultOutE = alu_c;
   assign ex.WriteDataE  = write_data;
   assign ex.PCPlus4E    = idex_q.pc_plus4;
   assign ex.MultBusyE   = md_busy;

endmodule
